// File: rtl/measure_frame_length_pkg.sv
// Shared frame-length constants and length-emitter state type.
// The merge stage imports the same package so both sides agree on the length format.
package measure_frame_length_pkg;

  localparam int FRAME_LENGTH_WIDTH = 16;
  localparam int FRAME_LENGTH_BEATS = FRAME_LENGTH_WIDTH / 8;

  typedef enum logic {
    LEN_EMPTY = 1'b0,
    LEN_FULL  = 1'b1
  } len_state_e;

endpackage

// File: rtl/measure_frame_length.sv
// Byte-counting pass-through for an 8-bit AXI4-Stream.
// Each frame's length is emitted MSB first on a separate length stream.
module measure_frame_length
  import measure_frame_length_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int LENGTH_WIDTH = FRAME_LENGTH_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_frame_length_tdata,
  output logic                  m_axis_frame_length_tvalid,
  input  logic                  m_axis_frame_length_tready,
  output logic                  m_axis_frame_length_tlast,
  output logic                  frame_length_overflow
);

  localparam int LENGTH_BEATS = LENGTH_WIDTH / DATA_WIDTH;
  localparam int IDX_W = (LENGTH_BEATS > 1) ? $clog2(LENGTH_BEATS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LENGTH_BEATS - 1);
  localparam logic [LENGTH_WIDTH-1:0] CNT_MAX = '1;

  if (DATA_WIDTH != 8) begin : g_bad_data_width
    $error("measure_frame_length: DATA_WIDTH must be 8");
  end
  if ((LENGTH_WIDTH % DATA_WIDTH) != 0) begin : g_bad_length_width
    $error("measure_frame_length: LENGTH_WIDTH must be a multiple of DATA_WIDTH");
  end

  len_state_e              state_q, state_d;
  logic [LENGTH_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [LENGTH_WIDTH-1:0] len_q, len_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    sat_q, sat_d;
  logic                    ovf_q, ovf_d;

  logic                    len_full;
  logic                    stall;
  logic                    in_hs;
  logic                    last_hs;
  logic                    len_hs;
  logic                    cnt_at_max;
  logic [DATA_WIDTH-1:0]   len_byte;

  assign len_full   = (state_q == LEN_FULL);
  // Only the closing beat waits for the previous length to drain.
  assign stall      = s_axis_tlast & len_full;
  assign cnt_at_max = (beat_cnt_q == CNT_MAX);

  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tlast  = s_axis_tlast;
  assign m_axis_tvalid = s_axis_tvalid & ~stall & rstn;
  assign s_axis_tready = m_axis_tready & ~stall & rstn;

  assign in_hs   = s_axis_tvalid & s_axis_tready;
  assign last_hs = in_hs & s_axis_tlast;
  assign len_hs  = m_axis_frame_length_tvalid & m_axis_frame_length_tready;

  always_comb begin
    len_byte = '0;
    for (int b = 0; b < LENGTH_BEATS; b++) begin
      if (idx_q == IDX_W'(b)) begin
        len_byte = len_q[LENGTH_WIDTH-1-DATA_WIDTH*b -: DATA_WIDTH];
      end
    end
  end

  assign m_axis_frame_length_tvalid = len_full;
  assign m_axis_frame_length_tdata  = len_full ? len_byte : '0;
  assign m_axis_frame_length_tlast  = len_full & (idx_q == IDX_LAST);
  assign frame_length_overflow      = ovf_q;

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
    idx_d      = idx_q;
    sat_d      = sat_q;
    ovf_d      = 1'b0;

    if (last_hs) begin
      len_d      = cnt_at_max ? CNT_MAX : beat_cnt_q + 1'b1;
      ovf_d      = sat_q | cnt_at_max;
      beat_cnt_d = '0;
      sat_d      = 1'b0;
    end else if (in_hs) begin
      if (cnt_at_max) begin
        sat_d = 1'b1;
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end

    unique case (state_q)
      LEN_EMPTY: begin
        if (last_hs) begin
          state_d = LEN_FULL;
          idx_d   = '0;
        end
      end
      LEN_FULL: begin
        if (len_hs) begin
          if (idx_q == IDX_LAST) begin
            state_d = LEN_EMPTY;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= LEN_EMPTY;
      beat_cnt_q <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      sat_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      sat_q      <= sat_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule
